turn_input_arbiter: RTL and testbench
=====================================

Name: turn_input_arbiter

Overview:
- Sits between the two players' debounced, synchronised push-buttons and the board-update logic of the Connect Four game.
- Detects rising edges on each button internally and accepts input only from the player whose turn it is.
- Moves a per-turn column cursor and issues drop requests to the board with a req/ack handshake.
- Alternates turns after accepted moves, enforces an optional turn timeout, and freezes on game over.

Parameters:
NUM_COLS, 7, number of board columns (≥2)
COL_W, 3, width of column index (2^COL_W ≥ NUM_COLS)
TIMEOUT_CYCLES, 0, turn time limit in clk cycles; 0 disables the timeout
TMR_W, 32, width of turn timer (2^TMR_W > TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
btn_left  input  2  move-left buttons, bit0 = player 1, bit1 = player 2
btn_right  input  2  move-right buttons, same indexing
btn_drop  input  2  drop buttons, same indexing
game_over  input  1  level from win/draw detector
drop_ack  input  1  board has processed the current drop_req
drop_ok  input  1  valid with drop_ack: 1 = piece placed, 0 = column full
drop_req  output  1  drop request, held until acknowledged
drop_col  output  COL_W  column of the request, stable while drop_req=1
drop_player  output  1  0 = player 1, 1 = player 2, stable while drop_req=1
cursor_col  output  COL_W  current cursor column for display
active_player  output  1  player whose turn it is
turn_expired  output  1  one-cycle pulse when a turn times out
in_game_over  output  1  high in GAME_OVER state

Behaviour:
- Reset values: state=P1_TURN; cursor_col=NUM_COLS/2 (3 at default); active_player=0; drop_req=0; drop_col=0; drop_player=0; turn_expired=0; in_game_over=0; timer=0; all button history registers=0.
- Edge detect per button bit: edge = btn & ~prev, with prev <= btn every cycle in every state.
- A button held through reset produces one edge on the first clock after reset.
- Only edges of the active player's buttons are acted on. All other edges are discarded and never queued.
- States: P1_TURN, P2_TURN, WAIT_ACK, GAME_OVER. active_player = 0 in P1_TURN, 1 in P2_TURN, and is held in WAIT_ACK.
- Turn state, priority within one cycle (highest first):
  - game_over=1: go to GAME_OVER.
  - Drop edge: capture drop_col=cursor_col and drop_player=active_player, set drop_req=1, go to WAIT_ACK. Left/right edges in the same cycle are ignored.
  - Left and right edges together: no cursor change.
  - Left edge alone: cursor_col decrements, wrapping 0 -> NUM_COLS-1.
  - Right edge alone: cursor_col increments, wrapping NUM_COLS-1 -> 0.
  - Timer expiry: handled as described under Timer below.
- Latency: every action takes effect at the first posedge where the active button is sampled high. Outputs are registered, so they are visible one cycle after the input is sampled.
- WAIT_ACK:
  - drop_req stays 1 and drop_col/drop_player stay constant until drop_ack is sampled 1.
  - At that edge drop_req <= 0, so drop_req is low in the following cycle.
  - drop_ok=1: switch to the other player's turn, cursor_col <= NUM_COLS/2, timer cleared.
  - drop_ok=0: return to the same player's turn; cursor_col and timer are unchanged.
  - game_over during WAIT_ACK: the handshake completes first; GAME_OVER is entered on the ack edge instead of a turn state.
  - drop_ack while not in WAIT_ACK: ignored.
- Timer (only when TIMEOUT_CYCLES>0):
  - Counts clk cycles in the turn states; holds its value in WAIT_ACK.
  - Cleared on any accepted left/right move and on a turn change.
  - When timer == TIMEOUT_CYCLES-1 with no accepted action that cycle: pass the turn to the other player, cursor_col <= NUM_COLS/2, timer <= 0, turn_expired=1 for exactly one cycle.
  - An accepted action in the same cycle wins over expiry.
- GAME_OVER:
  - Absorbing until reset; in_game_over=1; drop_req=0; cursor_col frozen; all edges ignored.
- Asserting reset mid-handshake drops drop_req asynchronously; the board must treat this as an abandoned request.

Test Plan:
- Reset, then pulse btn_right[0] four times -> cursor_col 4,5,6,0. Then btn_left[0] once -> 6. Pulses on btn_right[1] leave cursor unchanged.
- Hold btn_drop[0] high for 5 cycles with cursor=2 -> exactly one drop_req. drop_col=2, drop_player=0, held for 3 cycles until drop_ack=1, drop_ok=1. Next cycle drop_req=0, active_player=1, cursor_col=3.
- Column full: drop with drop_ok=0 -> active_player remains 0, cursor unchanged; btn edges arriving during WAIT_ACK are discarded.
- TIMEOUT_CYCLES=10, no input -> turn_expired pulses at cycle 10, active_player toggles, cursor_col=3. A right press at cycle 9 cancels expiry and restarts the count.
- game_over asserted in P2_TURN -> in_game_over=1 next cycle and drop presses produce no drop_req. Asserted during WAIT_ACK -> ack completes, then GAME_OVER.
- Assert reset while drop_req=1 -> drop_req=0 immediately without a clock edge; state P1_TURN, cursor_col=3.

Source files
------------

// File: rtl/turn_input_arbiter.sv
// Turn arbiter for Connect Four: filters the two players' buttons down to the
// active player, steers the column cursor and hands drops to the board via req/ack.
module turn_input_arbiter #(
  parameter int NUM_COLS       = 7,
  parameter int COL_W          = 3,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMR_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       btn_left,
  input  logic [1:0]       btn_right,
  input  logic [1:0]       btn_drop,
  input  logic             game_over,
  input  logic             drop_ack,
  input  logic             drop_ok,
  output logic             drop_req,
  output logic [COL_W-1:0] drop_col,
  output logic             drop_player,
  output logic [COL_W-1:0] cursor_col,
  output logic             active_player,
  output logic             turn_expired,
  output logic             in_game_over
);

  typedef enum logic [1:0] {
    P1_TURN,
    P2_TURN,
    WAIT_ACK,
    GAME_OVER
  } state_t;

  localparam logic [COL_W-1:0] MID_COL      = COL_W'(NUM_COLS / 2);
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(NUM_COLS - 1);
  localparam bit               TIMER_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [1:0]       left_prev, right_prev, drop_prev;
  logic [1:0]       left_edge, right_edge, drop_edge;
  logic [TMR_W-1:0] timer;
  logic             my_left, my_right, my_drop;
  logic             move_left, move_right;
  logic             timer_hit;

  // Only the active player's edges matter; the other player's are simply dropped.
  assign left_edge  = btn_left  & ~left_prev;
  assign right_edge = btn_right & ~right_prev;
  assign drop_edge  = btn_drop  & ~drop_prev;

  assign my_left    = left_edge[active_player];
  assign my_right   = right_edge[active_player];
  assign my_drop    = drop_edge[active_player];
  assign move_left  = my_left & ~my_right;
  assign move_right = my_right & ~my_left;
  assign timer_hit  = TIMER_EN && (timer == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= P1_TURN;
      left_prev     <= '0;
      right_prev    <= '0;
      drop_prev     <= '0;
      timer         <= '0;
      cursor_col    <= MID_COL;
      active_player <= 1'b0;
      drop_req      <= 1'b0;
      drop_col      <= '0;
      drop_player   <= 1'b0;
      turn_expired  <= 1'b0;
      in_game_over  <= 1'b0;
    end else begin
      left_prev    <= btn_left;
      right_prev   <= btn_right;
      drop_prev    <= btn_drop;
      turn_expired <= 1'b0;

      case (state)
        P1_TURN, P2_TURN: begin
          if (game_over) begin
            state        <= GAME_OVER;
            in_game_over <= 1'b1;
          end else if (my_drop) begin
            drop_req    <= 1'b1;
            drop_col    <= cursor_col;
            drop_player <= active_player;
            state       <= WAIT_ACK;
          end else if (move_left) begin
            cursor_col <= (cursor_col == '0) ? LAST_COL : cursor_col - COL_W'(1);
            timer      <= '0;
          end else if (move_right) begin
            cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + COL_W'(1);
            timer      <= '0;
          end else if (timer_hit) begin
            active_player <= ~active_player;
            state         <= active_player ? P1_TURN : P2_TURN;
            cursor_col    <= MID_COL;
            timer         <= '0;
            turn_expired  <= 1'b1;
          end else if (TIMER_EN) begin
            timer <= timer + TMR_W'(1);
          end
        end

        // The handshake always completes before game over takes effect.
        WAIT_ACK: begin
          if (drop_ack) begin
            drop_req <= 1'b0;
            if (game_over) begin
              state        <= GAME_OVER;
              in_game_over <= 1'b1;
            end else if (drop_ok) begin
              active_player <= ~active_player;
              state         <= active_player ? P1_TURN : P2_TURN;
              cursor_col    <= MID_COL;
              timer         <= '0;
            end else begin
              state <= active_player ? P2_TURN : P1_TURN;
            end
          end
        end

        GAME_OVER: begin
          drop_req     <= 1'b0;
          in_game_over <= 1'b1;
        end

        default: begin
          state <= P1_TURN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_input_arbiter.sv
// Directed bench for turn_input_arbiter: one instance with the timeout disabled
// and one with a 10-cycle turn limit, both driven by the same stimulus.
module tb_turn_input_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_left = '0, btn_right = '0, btn_drop = '0;
  logic       game_over = 1'b0, drop_ack = 1'b0, drop_ok = 1'b0;

  logic       drop_req, drop_player, active_player, turn_expired, in_game_over;
  logic [2:0] drop_col, cursor_col;
  logic       to_drop_req, to_drop_player, to_active_player, to_turn_expired, to_in_game_over;
  logic [2:0] to_drop_col, to_cursor_col;

  int tests_run = 0;
  int tests_failed = 0;
  int seen = 0;
  int seen_default = 0;

  always #5 clk = ~clk;

  turn_input_arbiter dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .game_over(game_over), .drop_ack(drop_ack), .drop_ok(drop_ok),
    .drop_req(drop_req), .drop_col(drop_col), .drop_player(drop_player),
    .cursor_col(cursor_col), .active_player(active_player),
    .turn_expired(turn_expired), .in_game_over(in_game_over)
  );

  turn_input_arbiter #(.TIMEOUT_CYCLES(10)) dut_to (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .game_over(game_over), .drop_ack(drop_ack), .drop_ok(drop_ok),
    .drop_req(to_drop_req), .drop_col(to_drop_col), .drop_player(to_drop_player),
    .cursor_col(to_cursor_col), .active_player(to_active_player),
    .turn_expired(to_turn_expired), .in_game_over(to_in_game_over)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge that consumed them.
  task automatic applyStimulus(input logic [1:0] l, input logic [1:0] r, input logic [1:0] d,
                               input logic ack, input logic ok, input logic gov);
    btn_left  = l;
    btn_right = r;
    btn_drop  = d;
    drop_ack  = ack;
    drop_ok   = ok;
    game_over = gov;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input logic [1:0] held_right);
    reset     = 1'b1;
    btn_left  = '0;
    btn_right = held_right;
    btn_drop  = '0;
    game_over = 1'b0;
    drop_ack  = 1'b0;
    drop_ok   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    doReset(2'b00);
    checkOutput("reset cursor", cursor_col, 3);
    checkOutput("reset active", active_player, 0);
    checkOutput("reset drop_req", drop_req, 0);
    checkOutput("reset drop_col", drop_col, 0);
    checkOutput("reset drop_player", drop_player, 0);
    checkOutput("reset in_game_over", in_game_over, 0);
    checkOutput("reset turn_expired", turn_expired, 0);

    // Cursor right with wrap, then left wrap back
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0); checkOutput("right 1", cursor_col, 4); idleCycle();
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0); checkOutput("right 2", cursor_col, 5); idleCycle();
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0); checkOutput("right 3", cursor_col, 6); idleCycle();
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0); checkOutput("right wrap", cursor_col, 0); idleCycle();
    applyStimulus(2'b01, 2'b00, 2'b00, 0, 0, 0); checkOutput("left wrap", cursor_col, 6); idleCycle();
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0); checkOutput("p2 right ignored", cursor_col, 6); idleCycle();
    applyStimulus(2'b01, 2'b01, 2'b00, 0, 0, 0); checkOutput("left+right no move", cursor_col, 6); idleCycle();

    // Walk to column 2 and drop with the button held for five cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 0, 0, 0);
      idleCycle();
    end
    checkOutput("cursor at 2", cursor_col, 2);
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    checkOutput("drop req", drop_req, 1);
    checkOutput("drop col", drop_col, 2);
    checkOutput("drop player", drop_player, 0);
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    checkOutput("drop req held", drop_req, 1);
    checkOutput("drop col held", drop_col, 2);
    applyStimulus(2'b00, 2'b00, 2'b01, 1, 1, 0);
    checkOutput("ack drops req", drop_req, 0);
    checkOutput("turn to p2", active_player, 1);
    checkOutput("cursor recentred", cursor_col, 3);
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    checkOutput("held drop no repeat", drop_req, 0);
    idleCycle();

    // Player 2 hits a full column; a right edge during the handshake is discarded
    applyStimulus(2'b00, 2'b00, 2'b10, 0, 0, 0);
    checkOutput("p2 drop req", drop_req, 1);
    checkOutput("p2 drop player", drop_player, 1);
    checkOutput("p2 drop col", drop_col, 3);
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0);
    checkOutput("edge in wait ignored", cursor_col, 3);
    applyStimulus(2'b00, 2'b10, 2'b00, 1, 0, 0);
    checkOutput("full ack req low", drop_req, 0);
    checkOutput("full keeps p2", active_player, 1);
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0);
    checkOutput("edge not queued", cursor_col, 3);
    idleCycle();

    // Stray ack outside the handshake, p2 moves, p1 drop ignored
    applyStimulus(2'b00, 2'b00, 2'b00, 1, 1, 0);
    checkOutput("stray ack ignored", active_player, 1);
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0); checkOutput("p2 right", cursor_col, 4); idleCycle();
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0); checkOutput("p1 drop ignored", drop_req, 0); idleCycle();

    // Game over from P2_TURN freezes everything
    applyStimulus(2'b00, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("game over flag", in_game_over, 1);
    applyStimulus(2'b00, 2'b00, 2'b10, 0, 0, 0); checkOutput("no drop after over", drop_req, 0); idleCycle();
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0); checkOutput("cursor frozen", cursor_col, 4); idleCycle();
    checkOutput("over absorbing", in_game_over, 1);

    // Game over during the handshake waits for the ack
    doReset(2'b00);
    checkOutput("reset clears over", in_game_over, 0);
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    checkOutput("drop before over", drop_req, 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 0, 0, 1);
    checkOutput("over waits req", drop_req, 1);
    checkOutput("over waits flag", in_game_over, 0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1, 1, 1);
    checkOutput("over ack req low", drop_req, 0);
    checkOutput("over after ack", in_game_over, 1);
    idleCycle();

    // Asynchronous reset abandons an outstanding request
    doReset(2'b00);
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0); idleCycle();
    applyStimulus(2'b00, 2'b00, 2'b01, 0, 0, 0);
    checkOutput("req before async reset", drop_req, 1);
    checkOutput("col before async reset", drop_col, 4);
    btn_drop = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset req", drop_req, 0);
    checkOutput("async reset cursor", cursor_col, 3);

    // A button held through reset yields exactly one edge
    doReset(2'b01);
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("held through reset", cursor_col, 4);
    applyStimulus(2'b00, 2'b01, 2'b00, 0, 0, 0);
    checkOutput("held one edge only", cursor_col, 4);

    // Timeout: expiry on the tenth idle edge, and a move on the last cycle cancels it
    doReset(2'b00);
    seen = 0;
    seen_default = 0;
    for (int i = 0; i < 9; i++) begin
      idleCycle();
      seen += int'(to_turn_expired);
      seen_default += int'(turn_expired);
    end
    checkOutput("no early expiry", seen, 0);
    idleCycle();
    seen_default += int'(turn_expired);
    checkOutput("expiry pulse", to_turn_expired, 1);
    checkOutput("expiry passes turn", to_active_player, 1);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      idleCycle();
      seen += int'(to_turn_expired);
      seen_default += int'(turn_expired);
    end
    checkOutput("expiry one cycle", seen, 0);
    applyStimulus(2'b00, 2'b10, 2'b00, 0, 0, 0);
    seen_default += int'(turn_expired);
    checkOutput("move beats expiry", to_turn_expired, 0);
    checkOutput("move beats expiry player", to_active_player, 1);
    checkOutput("move beats expiry cursor", to_cursor_col, 4);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      idleCycle();
      seen += int'(to_turn_expired);
      seen_default += int'(turn_expired);
    end
    checkOutput("count restarted", seen, 0);
    idleCycle();
    seen_default += int'(turn_expired);
    checkOutput("second expiry", to_turn_expired, 1);
    checkOutput("second expiry player", to_active_player, 0);
    checkOutput("second expiry cursor", to_cursor_col, 3);
    checkOutput("disabled timer silent", seen_default, 0);
    checkOutput("disabled timer player", active_player, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
